// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: host write channel plus the single-port frame-buffer
// RAM port of vga_fb_arbiter, grouped for connection as one bundle.
//   master : environment side (host issuing writes, RAM returning read data)
//   slave  : arbiter side
interface vga_fb_arbiter_if;
   logic        host_valid;
   logic        host_ready;
   logic [14:0] host_addr;
   logic [11:0] host_data;
   logic        mem_en;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;

   modport master (
      output host_valid, host_addr, host_data, mem_rdata,
      input  host_ready, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  host_valid, host_addr, host_data, mem_rdata,
      output host_ready, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame-buffer RAM between the VGA
// display fetch and a FIFO-buffered host write port. The frame buffer holds
// one 12-bit colour per 4x4 screen-pixel cell. Display reads always win;
// queued host writes drain in order in cycles the display does not claim.
// Host writes to cells outside the frame buffer are accepted and dropped.
//
// Build option: define VGA_FB_BLANK_WRITE_EN to restrict host writes to
// blanking cycles (vid_on=0) for tear-free updates. Undefined (default),
// host writes use any cycle without a display read.
module vga_fb_arbiter #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FB_W       = 160,
   parameter int unsigned FB_H       = 120
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             vid_on,
   input  logic             H_sync_in,
   input  logic             V_sync_in,
   input  logic [9:0]       pix_x,
   input  logic [9:0]       pix_y,
   vga_fb_arbiter_if.slave  bus,
   output logic             H_sync,
   output logic             V_sync,
   output logic [11:0]      RGB_out
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [14:0] CELLS = 15'(FB_W * FB_H);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DISP = 2'd1,
      S_HOST = 2'd2
   } state_t;

   state_t state;
   state_t grant;

   // Host write FIFO
   logic [14:0]      fifo_addr [FIFO_DEPTH];
   logic [11:0]      fifo_data [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [PTR_W-1:0] wr_idx;
   logic [PTR_W-1:0] rd_idx;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic [14:0]      head_addr;
   logic [11:0]      head_data;

   // Display side
   logic             run;
   logic             disp_req;
   logic [14:0]      disp_addr;
   logic             host_slot;
   logic [11:0]      pix_reg;
   logic             vid_d1, vid_d2;
   logic             hs_d1, hs_d2;
   logic             vs_d1, vs_d2;

   assign wr_idx     = wr_ptr[PTR_W-1:0];
   assign rd_idx     = rd_ptr[PTR_W-1:0];
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
   assign head_addr  = fifo_addr[rd_idx];
   assign head_data  = fifo_data[rd_idx];

   // host_ready stays low until the first clock edge after reset release
   assign bus.host_ready = run && !fifo_full;
   assign push           = bus.host_valid && bus.host_ready;

   // One RAM fetch serves the four horizontal pixels of a cell
   assign disp_req  = vid_on && (pix_x[1:0] == 2'b00);
   assign disp_addr = 15'(pix_y >> 2) * 15'(FB_W) + 15'(pix_x >> 2);

`ifdef VGA_FB_BLANK_WRITE_EN
   assign host_slot = !vid_on;
`else
   assign host_slot = 1'b1;
`endif

   // Grant register: remembers which access was issued last cycle so the
   // read data returning this cycle can be captured
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= grant;
      end
   end

   // Grant decision and RAM port drive for the current cycle; the reset
   // input gates the port directly so it goes quiet asynchronously
   always_comb begin
      grant         = S_IDLE;
      pop           = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (i_rst_n) begin
         if (disp_req) begin
            grant        = S_DISP;
            bus.mem_en   = 1'b1;
            bus.mem_addr = disp_addr;
         end else if (!fifo_empty && host_slot) begin
            pop = 1'b1;
            // out-of-range entries are popped without touching the RAM
            if (head_addr < CELLS) begin
               grant         = S_HOST;
               bus.mem_en    = 1'b1;
               bus.mem_we    = 1'b1;
               bus.mem_addr  = head_addr;
               bus.mem_wdata = head_data;
            end
         end
      end
   end

   // Run flag: enables host_ready from the first edge after reset release
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // FIFO pointers: extra MSB distinguishes full from empty
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // FIFO storage: contents are only meaningful between the pointers
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_addr[wr_idx] <= bus.host_addr;
         fifo_data[wr_idx] <= bus.host_data;
      end
   end

   // Pixel register: loads the RAM data returned for last cycle's display read
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pix_reg <= '0;
      end else if (state == S_DISP) begin
         pix_reg <= bus.mem_rdata;
      end
   end

   // Two-stage delay of vid_on and syncs, matching the read-capture latency
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vid_d1 <= 1'b0;
         vid_d2 <= 1'b0;
         hs_d1  <= 1'b0;
         hs_d2  <= 1'b0;
         vs_d1  <= 1'b0;
         vs_d2  <= 1'b0;
      end else begin
         vid_d1 <= vid_on;
         vid_d2 <= vid_d1;
         hs_d1  <= H_sync_in;
         hs_d2  <= hs_d1;
         vs_d1  <= V_sync_in;
         vs_d2  <= vs_d1;
      end
   end

   assign H_sync  = hs_d2;
   assign V_sync  = vs_d2;
   assign RGB_out = vid_d2 ? pix_reg : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized stimulus against a behavioural model of the
// frame-buffer arbiter, plus directed scenarios with literal expectations.
module tb_vga_fb_arbiter;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned FB_W  = 160;
   localparam int unsigned FB_H  = 120;
   localparam int unsigned CELLS = FB_W * FB_H;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        vid_on = 1'b0;
   logic        hs_in  = 1'b0;
   logic        vs_in  = 1'b0;
   logic [9:0]  pix_x  = '0;
   logic [9:0]  pix_y  = '0;
   logic        H_sync;
   logic        V_sync;
   logic [11:0] RGB_out;
   logic [11:0] rdata  = '0;

   int unsigned checks = 0;
   int unsigned errors = 0;

   vga_fb_arbiter_if bus ();

   vga_fb_arbiter #(.FIFO_DEPTH(DEPTH), .FB_W(FB_W), .FB_H(FB_H)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .vid_on    (vid_on),
      .H_sync_in (hs_in),
      .V_sync_in (vs_in),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .bus       (bus),
      .H_sync    (H_sync),
      .V_sync    (V_sync),
      .RGB_out   (RGB_out)
   );

   always #5 clk = ~clk;

   // Power-on RAM contents; cells 0 and 1 fixed for the directed fetch test
   function automatic logic [11:0] init_val(input int unsigned a);
      if (a == 0) return 12'hF00;
      if (a == 1) return 12'h0F0;
      return 12'((a * 37 + 11) ^ (a >> 3));
   endfunction

   // Frame-buffer RAM, one-cycle read latency
   logic [11:0] ram   [32768];
   bit          ram_w [32768];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            ram[bus.mem_addr]   <= bus.mem_wdata;
            ram_w[bus.mem_addr] <= 1'b1;
         end else begin
            rdata <= ram_w[bus.mem_addr] ? ram[bus.mem_addr] : init_val(32'(bus.mem_addr));
         end
      end
   end
   assign bus.mem_rdata = rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model state
   typedef struct packed { logic [14:0] addr; logic [11:0] data; } wr_t;
   wr_t         mq[$];
   logic [11:0] shw   [32768];
   bit          shw_v [32768];
   bit          m_run = 1'b0;
   bit          vid_h1 = 1'b0, vid_h2 = 1'b0;
   bit          hs_h1 = 1'b0, hs_h2 = 1'b0;
   bit          vs_h1 = 1'b0, vs_h2 = 1'b0;
   logic [11:0] last_h1 = '0, last_h2 = '0;

   // Model: outputs are the inputs of two cycles ago, RGB the most recent
   // cell fetched at least two cycles ago; writes drain in order when idle
   always @(negedge clk) begin : model
      logic        exp_ready;
      logic        exp_disp;
      logic        slot_ok;
      logic [14:0] daddr;
      logic [11:0] last_now;
      wr_t         head;
      wr_t         w;
      if (!rst_n) begin
         chk("rst_host_ready", 32'(bus.host_ready), 0);
         chk("rst_mem_en", 32'(bus.mem_en), 0);
         chk("rst_mem_we", 32'(bus.mem_we), 0);
         chk("rst_mem_addr", 32'(bus.mem_addr), 0);
         chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
         chk("rst_rgb", 32'(RGB_out), 0);
         chk("rst_h_sync", 32'(H_sync), 0);
         chk("rst_v_sync", 32'(V_sync), 0);
         mq.delete();
         m_run = 1'b0;
         vid_h1 = 0; vid_h2 = 0; hs_h1 = 0; hs_h2 = 0; vs_h1 = 0; vs_h2 = 0;
         last_h1 = '0; last_h2 = '0;
      end else begin
`ifdef VGA_FB_BLANK_WRITE_EN
         slot_ok = !vid_on;
`else
         slot_ok = 1'b1;
`endif
         exp_ready = m_run && (mq.size() < DEPTH);
         exp_disp  = vid_on && ((int'(pix_x) % 4) == 0);
         daddr     = 15'((int'(pix_y) / 4) * FB_W + int'(pix_x) / 4);
         chk("host_ready", 32'(bus.host_ready), 32'(exp_ready));
         chk("rgb_out", 32'(RGB_out), vid_h2 ? 32'(last_h2) : 0);
         chk("h_sync", 32'(H_sync), 32'(hs_h2));
         chk("v_sync", 32'(V_sync), 32'(vs_h2));
         last_now = last_h1;
         if (exp_disp) begin
            chk("disp_mem_en", 32'(bus.mem_en), 1);
            chk("disp_mem_we", 32'(bus.mem_we), 0);
            chk("disp_mem_addr", 32'(bus.mem_addr), 32'(daddr));
            last_now = shw_v[daddr] ? shw[daddr] : init_val(32'(daddr));
         end else if (mq.size() > 0 && slot_ok) begin
            head = mq.pop_front();
            if (int'(head.addr) < int'(CELLS)) begin
               chk("host_mem_en", 32'(bus.mem_en), 1);
               chk("host_mem_we", 32'(bus.mem_we), 1);
               chk("host_mem_addr", 32'(bus.mem_addr), 32'(head.addr));
               chk("host_mem_wdata", 32'(bus.mem_wdata), 32'(head.data));
               shw[head.addr]   = head.data;
               shw_v[head.addr] = 1'b1;
            end else begin
               chk("discard_mem_en", 32'(bus.mem_en), 0);
            end
         end else begin
            chk("idle_mem_en", 32'(bus.mem_en), 0);
         end
         if (bus.host_valid && exp_ready) begin
            w.addr = bus.host_addr;
            w.data = bus.host_data;
            mq.push_back(w);
         end
         m_run   = 1'b1;
         vid_h2  = vid_h1;  vid_h1  = vid_on;
         hs_h2   = hs_h1;   hs_h1   = hs_in;
         vs_h2   = vs_h1;   vs_h1   = vs_in;
         last_h2 = last_h1; last_h1 = last_now;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time %0t, limit 2000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0]  exp028 [10];
      int unsigned  accepts;
      int unsigned  writes;
      int unsigned  nwr;
      int unsigned  cnt;
      int unsigned  mode;
      int unsigned  len;
      int unsigned  hp;
      exp028 = '{12'h000, 12'h000, 12'hF00, 12'hF00, 12'hF00, 12'hF00,
                 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0};
      bus.host_valid = 1'b0;
      bus.host_addr  = '0;
      bus.host_data  = '0;
      repeat (3) @(posedge clk);
      #1;

      // Display fetch after reset release: cells 0 and 1 over pix_x 0..7
      rst_n = 1'b1;
      pix_y = '0;
      for (int c = 0; c < 10; c++) begin
         pix_x  = 10'(c);
         vid_on = (c < 8);
         @(negedge clk);
         chk("req028_rgb", 32'(RGB_out), 32'(exp028[c]));
         if (c == 0 || c == 4) begin
            chk("req028_mem_en", 32'(bus.mem_en), 1);
            chk("req028_mem_addr", 32'(bus.mem_addr), 32'(c / 4));
         end
         @(posedge clk); #1;
      end

      // Host write accepted during a display-read cycle
      vid_on = 1'b1; pix_x = '0;
      bus.host_valid = 1'b1; bus.host_addr = 15'd5; bus.host_data = 12'hABC;
      @(negedge clk);
      chk("req029_accept", 32'(bus.host_ready), 1);
      chk("req029_disp_first", 32'(bus.mem_we), 0);
      @(posedge clk); #1;
      bus.host_valid = 1'b0;
`ifndef VGA_FB_BLANK_WRITE_EN
      pix_x = 10'd1;
      @(negedge clk);
      chk("req029_mem_we", 32'(bus.mem_we), 1);
      chk("req029_mem_addr", 32'(bus.mem_addr), 5);
      chk("req029_mem_wdata", 32'(bus.mem_wdata), 32'h0ABC);
`else
      for (int k = 1; k < 4; k++) begin
         pix_x = 10'(k);
         @(negedge clk);
         chk("req033_hold", 32'(bus.mem_en), 0);
         @(posedge clk); #1;
      end
      vid_on = 1'b0;
      @(negedge clk);
      chk("req033_mem_we", 32'(bus.mem_we), 1);
      chk("req033_mem_addr", 32'(bus.mem_addr), 5);
      chk("req033_mem_wdata", 32'(bus.mem_wdata), 32'h0ABC);
`endif
      @(posedge clk); #1;

      // Display every cycle: FIFO fills, nothing written, then drains in order
      vid_on = 1'b1; pix_x = '0;
      accepts = 0; writes = 0;
      for (int k = 0; k < 6; k++) begin
         bus.host_valid = 1'b1;
         bus.host_addr  = 15'(10 + k);
         bus.host_data  = 12'(12'h111 * (k + 1));
         @(negedge clk);
         if (bus.host_ready) accepts++;
         if (bus.mem_we) writes++;
         @(posedge clk); #1;
      end
      chk("req030_accepts", accepts, 4);
      chk("req030_writes_blocked", writes, 0);
      bus.host_valid = 1'b0;
      @(negedge clk);
      chk("req030_full_ready", 32'(bus.host_ready), 0);
      @(posedge clk); #1;
      vid_on = 1'b0;
      nwr = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.mem_we) begin
            chk("req030_order", 32'(bus.mem_addr), 10 + nwr);
            nwr++;
         end
         @(posedge clk); #1;
      end
      chk("req030_drained", nwr, 4);

      // Out-of-range host address: accepted, discarded at pop
      bus.host_valid = 1'b1; bus.host_addr = 15'(CELLS); bus.host_data = 12'h123;
      @(negedge clk);
      chk("req031_accept", 32'(bus.host_ready), 1);
      @(posedge clk); #1;
      bus.host_valid = 1'b0;
      @(negedge clk);
      chk("req031_no_mem_en", 32'(bus.mem_en), 0);
      @(posedge clk); #1;

      // Reset with three queued writes: async clear, no stale writes after
      vid_on = 1'b1; pix_x = '0; hs_in = 1'b1; vs_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.host_valid = 1'b1;
         bus.host_addr  = 15'(20 + k);
         bus.host_data  = 12'(k + 1);
         @(posedge clk); #1;
      end
      bus.host_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("req032_host_ready", 32'(bus.host_ready), 0);
      chk("req032_mem_en", 32'(bus.mem_en), 0);
      chk("req032_mem_addr", 32'(bus.mem_addr), 0);
      chk("req032_rgb", 32'(RGB_out), 0);
      chk("req032_h_sync", 32'(H_sync), 0);
      chk("req032_v_sync", 32'(V_sync), 0);
      @(posedge clk); #1;
      rst_n = 1'b1; vid_on = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.mem_en) cnt++;
         @(posedge clk); #1;
      end
      chk("req032_no_stale", cnt, 0);

      // Randomized segments: scan, display-every-cycle, blanking; random resets
      for (int seg = 0; seg < 60; seg++) begin
         mode = $urandom_range(0, 2);
         len  = $urandom_range(20, 80);
         hp   = $urandom_range(10, 95);
         if ($urandom_range(0, 15) == 0) begin
            #2;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         pix_y = 10'($urandom_range(0, 479));
         if (mode == 1) pix_x = 10'(4 * $urandom_range(0, 159));
         else           pix_x = 10'($urandom_range(0, 799));
         for (int i = 0; i < int'(len); i++) begin
            case (mode)
               0: begin
                  pix_x  = (pix_x == 10'd799) ? 10'd0 : pix_x + 10'd1;
                  vid_on = (pix_x < 10'd640);
               end
               1: vid_on = 1'b1;
               default: begin
                  vid_on = 1'b0;
                  pix_x  = 10'($urandom_range(0, 799));
               end
            endcase
            hs_in = 1'($urandom);
            vs_in = 1'($urandom);
            bus.host_valid = ($urandom_range(0, 99) < hp);
            bus.host_addr  = ($urandom_range(0, 31) == 0) ? 15'($urandom_range(CELLS, 32767))
                                                          : 15'($urandom_range(0, CELLS - 1));
            bus.host_data  = 12'($urandom);
            @(posedge clk); #1;
         end
      end

      bus.host_valid = 1'b0;
      vid_on = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
